// File: rtl/m2_sched_pkg.sv
// ---------------------------------------------------------------------------
// m2_sched_pkg : shared types and constants for the M2 IDCT block scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package m2_sched_pkg;

  localparam int ADDR_W          = 18;
  localparam int IDX_W           = 12;
  localparam int PRE_STRIDE_W    = 9;
  localparam int POST_STRIDE_W   = 8;

  localparam int DEF_Y_BLK_COLS  = 40;
  localparam int DEF_UV_BLK_COLS = 20;
  localparam int DEF_BLK_ROWS    = 30;
  localparam int DEF_PRE_Y_BASE  = 76800;
  localparam int DEF_POST_Y_BASE = 0;
  localparam int DEF_POST_U_BASE = 38400;
  localparam int DEF_POST_V_BASE = 57600;
  localparam int TOTAL_BLKS      = 2400;

  typedef enum logic [2:0] {
    S_SCH_IDLE   = 3'd0,
    S_SCH_LI_FS  = 3'd1,
    S_SCH_LI_CT  = 3'd2,
    S_SCH_MEGA_A = 3'd3,
    S_SCH_MEGA_B = 3'd4,
    S_SCH_LO_CS  = 3'd5,
    S_SCH_LO_WS  = 3'd6,
    S_SCH_DONE   = 3'd7
  } sch_state_e;

  typedef enum logic [1:0] {
    PL_Y = 2'd0,
    PL_U = 2'd1,
    PL_V = 2'd2
  } plane_e;

  function automatic plane_e next_plane(input plane_e p);
    case (p)
      PL_Y:    return PL_U;
      PL_U:    return PL_V;
      default: return PL_Y;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/m2_blk_addr_gen.sv
// ---------------------------------------------------------------------------
// m2_blk_addr_gen : plane/row/col block walker with registered base address
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m2_blk_addr_gen
  import m2_sched_pkg::*;
#(
  parameter int Y_BLK_COLS  = DEF_Y_BLK_COLS,
  parameter int UV_BLK_COLS = DEF_UV_BLK_COLS,
  parameter int BLK_ROWS    = DEF_BLK_ROWS,
  parameter int Y_BASE      = 0,
  parameter int U_BASE      = 0,
  parameter int V_BASE      = 0,
  parameter int Y_STRIDE    = 320,
  parameter int UV_STRIDE   = 160,
  parameter int COL_STEP    = 8,
  parameter int STRIDE_W    = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                advance_i,
  output logic [ADDR_W-1:0]   base_addr_o,
  output logic [STRIDE_W-1:0] row_stride_o,
  output logic [IDX_W-1:0]    blk_idx_o
);

  localparam int COL_W = $clog2(Y_BLK_COLS);
  localparam int ROW_W = $clog2(BLK_ROWS);
  localparam logic [COL_W-1:0] Y_LAST_COL  = COL_W'(Y_BLK_COLS - 1);
  localparam logic [COL_W-1:0] UV_LAST_COL = COL_W'(UV_BLK_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(BLK_ROWS - 1);

  plane_e              plane_q, plane_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d, last_col;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, plane_base;
  logic [STRIDE_W-1:0] stride_q, stride_d;

  always_comb begin
    plane_d  = plane_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    last_col = (plane_q == PL_Y) ? Y_LAST_COL : UV_LAST_COL;
    if (clear_i) begin
      plane_d = PL_Y;
      row_d   = '0;
      col_d   = '0;
      idx_d   = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 1'b1;
      if (col_q == last_col) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          plane_d = next_plane(plane_q);
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Address is formed from the next-state counters so it lands in the same
  // edge as the counter update, ahead of the matching start pulse.
  always_comb begin
    case (plane_d)
      PL_U: begin
        plane_base = ADDR_W'(U_BASE);
        stride_d   = STRIDE_W'(UV_STRIDE);
      end
      PL_V: begin
        plane_base = ADDR_W'(V_BASE);
        stride_d   = STRIDE_W'(UV_STRIDE);
      end
      default: begin
        plane_base = ADDR_W'(Y_BASE);
        stride_d   = STRIDE_W'(Y_STRIDE);
      end
    endcase
    addr_d = plane_base
           + ((ADDR_W'(row_d) * ADDR_W'(stride_d)) << 3)
           + (ADDR_W'(col_d) * ADDR_W'(COL_STEP));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plane_q  <= PL_Y;
      row_q    <= '0;
      col_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else if (clear_i || advance_i) begin
      plane_q  <= plane_d;
      row_q    <= row_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign base_addr_o  = addr_q;
  assign row_stride_o = stride_q;
  assign blk_idx_o    = idx_q;

endmodule

`default_nettype wire

// File: rtl/m2_block_scheduler.sv
// ---------------------------------------------------------------------------
// m2_block_scheduler : overlapped FS/CT/CS/WS sequencer over all Y/U/V blocks
// Optional stall counter: define M2_SCHED_PERF_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m2_block_scheduler
  import m2_sched_pkg::*;
#(
  parameter int Y_BLK_COLS  = DEF_Y_BLK_COLS,
  parameter int UV_BLK_COLS = DEF_UV_BLK_COLS,
  parameter int BLK_ROWS    = DEF_BLK_ROWS,
  parameter int PRE_Y_BASE  = DEF_PRE_Y_BASE,
  parameter int POST_Y_BASE = DEF_POST_Y_BASE,
  parameter int POST_U_BASE = DEF_POST_U_BASE,
  parameter int POST_V_BASE = DEF_POST_V_BASE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     fs_start_o,
  output logic                     ct_start_o,
  output logic                     cs_start_o,
  output logic                     ws_start_o,
  input  logic                     fs_done_i,
  input  logic                     ct_done_i,
  input  logic                     cs_done_i,
  input  logic                     ws_done_i,
  output logic [ADDR_W-1:0]        fs_base_addr_o,
  output logic [PRE_STRIDE_W-1:0]  fs_row_stride_o,
  output logic [ADDR_W-1:0]        ws_base_addr_o,
  output logic [POST_STRIDE_W-1:0] ws_row_stride_o,
  output logic [IDX_W-1:0]         fs_blk_idx_o,
`ifdef M2_SCHED_PERF_EN
  output logic [31:0]              stall_cycles_o,
`endif
  output logic [IDX_W-1:0]         ws_blk_idx_o
);

  localparam int PRE_Y_STRIDE   = Y_BLK_COLS * 8;
  localparam int PRE_UV_STRIDE  = UV_BLK_COLS * 8;
  localparam int POST_Y_STRIDE  = Y_BLK_COLS * 4;
  localparam int POST_UV_STRIDE = UV_BLK_COLS * 4;
  localparam int PRE_U_BASE     = PRE_Y_BASE + PRE_Y_STRIDE * BLK_ROWS * 8;
  localparam int PRE_V_BASE     = PRE_U_BASE + PRE_UV_STRIDE * BLK_ROWS * 8;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(BLK_ROWS * (Y_BLK_COLS + 2 * UV_BLK_COLS) - 1);

  sch_state_e state_q, state_d;
  logic fs_flag_q, ct_flag_q, cs_flag_q, ws_flag_q;
  logic fs_start_q, ct_start_q, cs_start_q, ws_start_q;
  logic busy_q, done_q;
  logic need_fs, need_ct, need_cs, need_ws, all_done, enter, accept;

  assign accept = (state_q == S_SCH_IDLE) && enable_i;

  // Exit decisions look only at the sticky flags, giving one cycle between
  // the last done pulse and the state change.
  always_comb begin
    state_d  = state_q;
    need_fs  = (state_q == S_SCH_LI_FS)  || (state_q == S_SCH_MEGA_A);
    need_ct  = (state_q == S_SCH_LI_CT)  || (state_q == S_SCH_MEGA_B);
    need_cs  = (state_q == S_SCH_MEGA_A) || (state_q == S_SCH_LO_CS);
    need_ws  = (state_q == S_SCH_MEGA_B) || (state_q == S_SCH_LO_WS);
    all_done = (!need_fs || fs_flag_q) && (!need_ct || ct_flag_q) &&
               (!need_cs || cs_flag_q) && (!need_ws || ws_flag_q);
    case (state_q)
      S_SCH_IDLE:   if (enable_i) state_d = S_SCH_LI_FS;
      S_SCH_LI_FS:  if (all_done) state_d = S_SCH_LI_CT;
      S_SCH_LI_CT:  if (all_done) state_d = S_SCH_MEGA_A;
      S_SCH_MEGA_A: if (all_done) state_d = S_SCH_MEGA_B;
      S_SCH_MEGA_B: if (all_done) state_d = (fs_blk_idx_o < LAST_IDX) ? S_SCH_MEGA_A
                                                                      : S_SCH_LO_CS;
      S_SCH_LO_CS:  if (all_done) state_d = S_SCH_LO_WS;
      S_SCH_LO_WS:  if (all_done) state_d = S_SCH_DONE;
      S_SCH_DONE:   state_d = S_SCH_IDLE;
      default:      state_d = S_SCH_IDLE;
    endcase
  end

  assign enter = (state_d != state_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_SCH_IDLE;
      fs_flag_q  <= 1'b0;
      ct_flag_q  <= 1'b0;
      cs_flag_q  <= 1'b0;
      ws_flag_q  <= 1'b0;
      fs_start_q <= 1'b0;
      ct_start_q <= 1'b0;
      cs_start_q <= 1'b0;
      ws_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fs_start_q <= enter && ((state_d == S_SCH_LI_FS)  || (state_d == S_SCH_MEGA_A));
      ct_start_q <= enter && ((state_d == S_SCH_LI_CT)  || (state_d == S_SCH_MEGA_B));
      cs_start_q <= enter && ((state_d == S_SCH_MEGA_A) || (state_d == S_SCH_LO_CS));
      ws_start_q <= enter && ((state_d == S_SCH_MEGA_B) || (state_d == S_SCH_LO_WS));
      done_q     <= enter && (state_d == S_SCH_DONE);
      if (accept) begin
        busy_q <= 1'b1;
      end else if (enter && (state_d == S_SCH_DONE)) begin
        busy_q <= 1'b0;
      end
      if (enter) begin
        fs_flag_q <= 1'b0;
        ct_flag_q <= 1'b0;
        cs_flag_q <= 1'b0;
        ws_flag_q <= 1'b0;
      end else begin
        fs_flag_q <= fs_flag_q | (fs_done_i & ~fs_start_q);
        ct_flag_q <= ct_flag_q | (ct_done_i & ~ct_start_q);
        cs_flag_q <= cs_flag_q | (cs_done_i & ~cs_start_q);
        ws_flag_q <= ws_flag_q | (ws_done_i & ~ws_start_q);
      end
    end
  end

  // A done coinciding with its own start is a unit protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!((fs_start_q && fs_done_i) || (ct_start_q && ct_done_i) ||
                (cs_start_q && cs_done_i) || (ws_start_q && ws_done_i)));
    end
  end

  m2_blk_addr_gen #(
    .Y_BLK_COLS (Y_BLK_COLS),
    .UV_BLK_COLS(UV_BLK_COLS),
    .BLK_ROWS   (BLK_ROWS),
    .Y_BASE     (PRE_Y_BASE),
    .U_BASE     (PRE_U_BASE),
    .V_BASE     (PRE_V_BASE),
    .Y_STRIDE   (PRE_Y_STRIDE),
    .UV_STRIDE  (PRE_UV_STRIDE),
    .COL_STEP   (8),
    .STRIDE_W   (PRE_STRIDE_W)
  ) u_fetch_addr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (accept),
    .advance_i   (enter && (state_d == S_SCH_MEGA_A)),
    .base_addr_o (fs_base_addr_o),
    .row_stride_o(fs_row_stride_o),
    .blk_idx_o   (fs_blk_idx_o)
  );

  m2_blk_addr_gen #(
    .Y_BLK_COLS (Y_BLK_COLS),
    .UV_BLK_COLS(UV_BLK_COLS),
    .BLK_ROWS   (BLK_ROWS),
    .Y_BASE     (POST_Y_BASE),
    .U_BASE     (POST_U_BASE),
    .V_BASE     (POST_V_BASE),
    .Y_STRIDE   (POST_Y_STRIDE),
    .UV_STRIDE  (POST_UV_STRIDE),
    .COL_STEP   (4),
    .STRIDE_W   (POST_STRIDE_W)
  ) u_write_addr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (accept),
    .advance_i   (enter && (state_q == S_SCH_MEGA_B)),
    .base_addr_o (ws_base_addr_o),
    .row_stride_o(ws_row_stride_o),
    .blk_idx_o   (ws_blk_idx_o)
  );

`ifdef M2_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (((state_q == S_SCH_MEGA_A) && (cs_flag_q ^ fs_flag_q)) ||
                 ((state_q == S_SCH_MEGA_B) && (ct_flag_q ^ ws_flag_q))) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

  assign fs_start_o = fs_start_q;
  assign ct_start_o = ct_start_q;
  assign cs_start_o = cs_start_q;
  assign ws_start_o = ws_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: doc/m2_block_scheduler.md
Name: m2_block_scheduler

Overview:
Top-level sequencer for the Milestone 2 IDCT pipeline. Walks all 8x8 blocks of the Y, U and V planes (2400 blocks), computing pre-IDCT fetch and post-IDCT write base addresses and strides for each. Issues start pulses to the four stage units (FS fetch S', CT compute T, CS compute S, WS write S) in the overlapped schedule LI -> {CS k | FS k+1} / {CT k+1 | WS k} -> LO. Sits between the top-level Milestone FSM and the FS/CT/CS/WS datapath units.

Parameters:
Y_BLK_COLS, 40, 8x8 block columns in Y (320 px)
UV_BLK_COLS, 20, block columns in U and V (160 px)
BLK_ROWS, 30, block rows per plane (240 px)
PRE_Y_BASE, 76800, pre-IDCT Y base; U = 153600, V = 192000 (derived)
POST_Y_BASE, 0, post-IDCT Y base; U = 38400, V = 57600 (parameters POST_U_BASE, POST_V_BASE)

Ports:
Clock  in  1  system clock
Resetn  in  1  async active-low reset
Enable  in  1  one-cycle start pulse for whole image
Done  out  1  one-cycle pulse after final WS completes
Busy  out  1  high from Enable accept to Done
fs_start, ct_start, cs_start, ws_start  out  1 each  one-cycle stage start pulses
fs_done, ct_done, cs_done, ws_done  in  1 each  one-cycle stage completion pulses
fs_base_addr  out  18  SRAM word address of block's top-left sample (pre-IDCT)
fs_row_stride  out  9  320 for Y, 160 for U/V
ws_base_addr  out  18  SRAM word address of block's first output word (post-IDCT, 2 px/word)
ws_row_stride  out  8  160 for Y, 80 for U/V
fs_blk_idx, ws_blk_idx  out  12  block indices 0..2399 in flight

Behaviour:
- Reset: all outputs 0, state S_SCH_IDLE, counters 0. Reset mid-operation aborts immediately; no further start pulses.
- Clock and reset are the single Clock and asynchronous active-low Resetn (async assert, sync deassert handled upstream).
- States: IDLE, LI_FS, LI_CT, MEGA_A, MEGA_B, LO_CS, LO_WS, DONE.
- IDLE: on Enable=1 -> LI_FS, fs_blk_idx=0, Busy=1. Enable while Busy ignored.
- Each state entry: assert its start(s) for exactly one cycle (cycle after entry), clear done-latches. Done pulses latched into per-unit sticky flags; done in the same cycle as that unit's start pulse is ignored (protocol error, flagged only in simulation assertion).
- Exit when all units of the state have latched done; transition on the cycle after the last done (1-cycle decision latency).
- LI_FS (FS blk 0) -> LI_CT (CT blk 0) -> MEGA_A.
- MEGA_A: CS blk k + FS blk k+1 -> MEGA_B. MEGA_B: CT blk k+1 + WS blk k -> MEGA_A if k+1 < 2399 else LO_CS. k increments on MEGA_B exit.
- LO_CS: CS blk 2399 -> LO_WS: WS blk 2399 -> DONE: Done=1 one cycle, Busy=0 -> IDLE.
- Block index -> (plane,r,c): idx<1200 Y, r=idx/40, c=idx%40; 1200..1799 U; 1800..2399 V with 20 cols. Implemented with incrementing plane/row/col counters, not division; col wraps to 0 and row increments; row wrap at 30 advances plane.
- Pre address: plane_base + r*8*stride + c*8. Post address: post_base + r*8*wstride + c*4. Registered; valid no later than the start pulse cycle and stable until the next start of that unit.
- Arithmetic unsigned, 18-bit, no overflow for given parameters.

Optional Feature:
M2_SCHED_PERF_EN: adds output stall_cycles (32) counting cycles in MEGA_A/MEGA_B where exactly one unit has latched done and the other has not; cleared on Enable, held after Done. Without macro: port absent, no counter logic.

Decomposition:
Package m2_sched_pkg: state enum type, plane enum (Y/U/V), base and stride constants, total block count 2400. One sub-module m2_blk_addr_gen (plane/row/col counters plus address compute), instantiated twice: fetch side and write side.

Test Plan:
- Enable, stub units return done 10 cycles after start -> first fs_start with fs_base_addr=76800, stride 320; Done after 2+2*2399+2 stage phases.
- fs_blk_idx=39 -> 77112; idx 40 -> 79360; ws for idx 40 -> 1280.
- idx 1200 -> fs 153600 stride 160, ws 38400 stride 80; idx 1800 -> fs 192000, ws 57600; idx 2399 -> fs 229272, ws 76236.
- MEGA_A with cs_done at cycle 5 and fs_done at cycle 40, then same-cycle dones -> transition exactly 1 cycle after last done both times; with PERF_EN stall_cycles increments by 35.
- Resetn low during MEGA_B block 500 -> all outputs 0 immediately, IDLE; new Enable restarts at idx 0.
- Enable pulsed while Busy -> ignored, no extra start pulses, indices unchanged.
